// File: rtl/bpred_event_counters_pkg.sv
// Shared definitions for the branch-predictor event counters.
// Counter index map and the W-stage event bundle.
package cvw;

  localparam int BPC_BRANCH      = 0;
  localparam int BPC_JUMP        = 1;
  localparam int BPC_RETURN      = 2;
  localparam int BPC_CALL        = 3;
  localparam int BPC_BPWRONG     = 4;
  localparam int BPC_DIRWRONG    = 5;
  localparam int BPC_BTAWRONG    = 6;
  localparam int BPC_RASWRONG    = 7;
  localparam int BPC_ICLASSWRONG = 8;
  localparam int BPC_NUM         = 9;

  localparam int BPC_SEL_W = 4;

  // One retired instruction as seen by the W stage.
  typedef struct packed {
    logic       valid;
    logic [3:0] cls;
    logic       bp_wrong;
    logic       dir_wrong;
    logic       bta_wrong;
    logic       ras_wrong;
    logic       iclass_wrong;
  } bpc_w_t;

  // Flatten a W bundle into one event bit per counter index.
  function automatic logic [BPC_NUM-1:0] bpc_events(
    input bpc_w_t w
  );
    logic [BPC_NUM-1:0] e;
    e                  = '0;
    e[BPC_BRANCH]      = w.cls[0];
    e[BPC_JUMP]        = w.cls[1];
    e[BPC_RETURN]      = w.cls[2];
    e[BPC_CALL]        = w.cls[3];
    e[BPC_BPWRONG]     = w.bp_wrong;
    e[BPC_DIRWRONG]    = w.dir_wrong;
    e[BPC_BTAWRONG]    = w.bta_wrong;
    e[BPC_RASWRONG]    = w.ras_wrong;
    e[BPC_ICLASSWRONG] = w.iclass_wrong;
    return e;
  endfunction

endpackage

// File: rtl/bpred_event_counters_ctr.sv
// One wrapping event counter with a sticky overflow flag.
// Priority: clear, then write, then increment, else hold.
module bpred_event_ctr
  import cvw::*;
#(
  parameter int CTR_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [CTR_W-1:0] wdata_i,
  input  logic             inc_i,
  output logic [CTR_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Next count/overflow; a write wins over and drops a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (wr_i) begin
      cnt_d = wdata_i;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CTR_W'(1);
      if (&cnt_q) ovf_d = 1'b1;
    end
  end

  // Counter and overflow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/bpred_event_counters.sv
// W-stage branch-predictor event counters with a CSR-style
// select/read/write port, inhibit mask and sticky overflow.
module bpred_event_counters
  import cvw::*;
#(
  parameter int CTR_W   = 64,
  parameter int NUM_CTR = BPC_NUM
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallW,
  input  logic                 FlushW,
  input  logic                 InstrValidM,
  input  logic [3:0]           InstrClassM,
  input  logic                 BPWrongM,
  input  logic                 BPDirPredWrongM,
  input  logic                 BTAWrongM,
  input  logic                 RASPredPCWrongM,
  input  logic                 IClassWrongM,
  input  logic [BPC_SEL_W-1:0] CtrSel,
  input  logic                 RdReq,
  output logic                 RdValid,
  output logic [CTR_W-1:0]     RdData,
  input  logic                 WrEn,
  input  logic [CTR_W-1:0]     WrData,
  input  logic                 MaskWrEn,
  input  logic [NUM_CTR-1:0]   MaskData,
  input  logic                 ClearAll,
  output logic [NUM_CTR-1:0]   OvfFlags
);

  bpc_w_t m_evt;
  bpc_w_t w_q, w_d;

  logic [NUM_CTR-1:0] mask_q, mask_d;
  logic [NUM_CTR-1:0] evt_w;
  logic [NUM_CTR-1:0] inc;
  logic [NUM_CTR-1:0] wr_hit;
  logic [CTR_W-1:0]   cnt [NUM_CTR];

  logic [CTR_W-1:0] rd_mux;
  logic [CTR_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q;

  assign m_evt = '{
    valid:        InstrValidM,
    cls:          InstrClassM,
    bp_wrong:     BPWrongM,
    dir_wrong:    BPDirPredWrongM,
    bta_wrong:    BTAWrongM,
    ras_wrong:    RASPredPCWrongM,
    iclass_wrong: IClassWrongM
  };

  // W event register: flush squashes unconditionally, stall holds.
  always_comb begin
    w_d = w_q;
    if (FlushW)       w_d = '0;
    else if (!StallW) w_d = m_evt;
  end

  // W event and inhibit-mask state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q    <= '0;
      mask_q <= '0;
    end else begin
      w_q    <= w_d;
      mask_q <= mask_d;
    end
  end

  // Mask reload; ClearAll deliberately leaves it alone.
  always_comb begin
    mask_d = mask_q;
    if (MaskWrEn) mask_d = MaskData;
  end

  // A stalled W is not counted, so a held instruction counts once.
  assign evt_w = NUM_CTR'(bpc_events(w_q));
  assign inc   = evt_w
               & {NUM_CTR{w_q.valid & ~StallW}}
               & ~mask_q;

  for (genvar i = 0; i < NUM_CTR; i++) begin : g_ctr
    assign wr_hit[i] = WrEn && (int'(CtrSel) == i);

    bpred_event_ctr #(
      .CTR_W (CTR_W)
    ) u_ctr (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (ClearAll),
      .wr_i    (wr_hit[i]),
      .wdata_i (WrData),
      .inc_i   (inc[i]),
      .cnt_o   (cnt[i]),
      .ovf_o   (OvfFlags[i])
    );
  end

  // Read mux; out-of-range selects read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CTR; i++) begin
      if (int'(CtrSel) == i) rd_mux = cnt[i];
    end
  end

  // RdData holds between requests.
  always_comb begin
    rd_data_d = rd_data_q;
    if (RdReq) rd_data_d = rd_mux;
  end

  // Read response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= RdReq;
    end
  end

  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;

endmodule

// File: tb/tb_bpred_event_counters.sv
// Bench for bpred_event_counters: directed scenarios with literal
// expectations, then random traffic against a behavioural model.
module tb_bpred_event_counters;
  import cvw::*;

  localparam int     CW   = 8;
  localparam int     NC   = 9;
  localparam longint MOD  = longint'(1) << CW;
  localparam longint MAXV = MOD - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          StallW, FlushW, InstrValidM;
  logic [3:0]    InstrClassM;
  logic          BPWrongM, BPDirPredWrongM, BTAWrongM;
  logic          RASPredPCWrongM, IClassWrongM;
  logic [3:0]    CtrSel;
  logic          RdReq, RdValid;
  logic [CW-1:0] RdData, WrData;
  logic          WrEn, MaskWrEn, ClearAll;
  logic [NC-1:0] MaskData, OvfFlags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bpred_event_counters #(
    .CTR_W   (CW),
    .NUM_CTR (NC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .StallW          (StallW),
    .FlushW          (FlushW),
    .InstrValidM     (InstrValidM),
    .InstrClassM     (InstrClassM),
    .BPWrongM        (BPWrongM),
    .BPDirPredWrongM (BPDirPredWrongM),
    .BTAWrongM       (BTAWrongM),
    .RASPredPCWrongM (RASPredPCWrongM),
    .IClassWrongM    (IClassWrongM),
    .CtrSel          (CtrSel),
    .RdReq           (RdReq),
    .RdValid         (RdValid),
    .RdData          (RdData),
    .WrEn            (WrEn),
    .WrData          (WrData),
    .MaskWrEn        (MaskWrEn),
    .MaskData        (MaskData),
    .ClearAll        (ClearAll),
    .OvfFlags        (OvfFlags)
  );

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, act, exp, $time);
    end
  endtask

  // Behavioural model: counters as plain integers, W as the
  // instruction waiting to retire, events listed by index.
  longint        m_ctr [NC];
  bit [NC-1:0]   m_ovf, m_mask, m_ev;
  bit            m_v, m_rdv, m_inc;
  longint        m_rdd;
  int            m_sel;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) m_ctr[i] = 0;
      m_ovf = '0; m_mask = '0; m_ev = '0;
      m_v = 0; m_rdv = 0; m_rdd = 0;
    end else begin
      m_sel = int'(CtrSel);
      m_rdv = RdReq;
      if (RdReq) m_rdd = (m_sel < NC) ? m_ctr[m_sel] : 0;
      for (int i = 0; i < NC; i++) begin
        m_inc = m_v && m_ev[i] && !StallW && !m_mask[i];
        if (ClearAll) begin
          m_ctr[i] = 0; m_ovf[i] = 0;
        end else if (WrEn && m_sel == i) begin
          m_ctr[i] = longint'(WrData); m_ovf[i] = 0;
        end else if (m_inc) begin
          if (m_ctr[i] == MAXV) m_ovf[i] = 1;
          m_ctr[i] = (m_ctr[i] + 1) % MOD;
        end
      end
      if (MaskWrEn) m_mask = MaskData;
      if (FlushW) begin
        m_v = 0; m_ev = '0;
      end else if (!StallW) begin
        m_v  = InstrValidM;
        m_ev = {IClassWrongM, RASPredPCWrongM, BTAWrongM,
                BPDirPredWrongM, BPWrongM, InstrClassM[3],
                InstrClassM[2], InstrClassM[1], InstrClassM[0]};
      end
    end
  end

  // Compare process: every cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    chk("cyc_rdvalid", 64'(RdValid), 64'(m_rdv));
    if (m_rdv) chk("cyc_rddata", 64'(RdData), 64'(m_rdd));
    chk("cyc_ovf", 64'(OvfFlags), 64'(m_ovf));
  end

  task automatic idle();
    StallW = 0; FlushW = 0; InstrValidM = 0; InstrClassM = 0;
    BPWrongM = 0; BPDirPredWrongM = 0; BTAWrongM = 0;
    RASPredPCWrongM = 0; IClassWrongM = 0;
    CtrSel = 0; RdReq = 0; WrEn = 0; WrData = 0;
    MaskWrEn = 0; MaskData = 0; ClearAll = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input int sel, input longint exp, input string n);
    CtrSel = sel[3:0];
    RdReq  = 1;
    tick();
    chk(n, 64'(RdData), 64'(exp));
  endtask

  task automatic wr(input int sel, input longint v);
    CtrSel = sel[3:0];
    WrEn   = 1;
    WrData = CW'(v);
    tick();
  endtask

  initial begin
    reset = 1;
    idle();
    tick(); tick();
    reset = 0;
    chk("rst_ovf", 64'(OvfFlags), 64'd0);
    chk("rst_rdvalid", 64'(RdValid), 64'd0);
    rd(0, 0, "rst_ctr0");

    // branch with wrong direction
    InstrValidM = 1; InstrClassM = 4'b0001; BPDirPredWrongM = 1;
    tick();
    tick();
    rd(0, 1, "t1_branch");
    rd(5, 1, "t1_dirwrong");
    rd(1, 0, "t1_jump");
    rd(4, 0, "t1_bpwrong");

    // call held three cycles by stall
    ClearAll = 1; tick();
    InstrValidM = 1; InstrClassM = 4'b1010; tick();
    repeat (3) begin
      InstrValidM = 1; InstrClassM = 4'b1010; StallW = 1;
      tick();
    end
    tick();
    rd(1, 1, "t2_jump");
    rd(3, 1, "t2_call");
    rd(0, 0, "t2_branch");

    // wrap at all-ones
    wr(4, MAXV);
    InstrValidM = 1; BPWrongM = 1; tick();
    tick();
    rd(4, 0, "t3_wrap");
    chk("t3_ovf4", 64'(OvfFlags[4]), 64'd1);
    wr(4, 5);
    chk("t3_ovf4_clr", 64'(OvfFlags[4]), 64'd0);
    rd(4, 5, "t3_write");

    // inhibit mask
    MaskWrEn = 1; MaskData = 9'h001; tick();
    repeat (10) begin
      InstrValidM = 1; InstrClassM = 4'b0001; tick();
    end
    tick();
    rd(0, 0, "t4_masked");
    MaskWrEn = 1; MaskData = 9'h000; tick();
    InstrValidM = 1; InstrClassM = 4'b0001; tick();
    tick();
    rd(0, 1, "t4_unmasked");

    // raise an overflow, then ClearAll against write + return
    wr(6, MAXV);
    InstrValidM = 1; BTAWrongM = 1; tick();
    tick();
    chk("t5_ovf6_set", 64'(OvfFlags[6]), 64'd1);
    InstrValidM = 1; InstrClassM = 4'b0110; tick();
    ClearAll = 1; WrEn = 1; CtrSel = 2; WrData = 7; tick();
    chk("t5_ovf_all", 64'(OvfFlags), 64'd0);
    rd(2, 0, "t5_return");
    rd(1, 0, "t5_jump");
    rd(6, 0, "t5_bta");

    // flushed IClassWrong, out-of-range select
    InstrValidM = 1; IClassWrongM = 1; FlushW = 1; tick();
    tick();
    rd(8, 0, "t6_flushed");
    wr(4, 9);
    wr(12, 33);
    rd(12, 0, "t6_sel12");
    rd(4, 9, "t6_ctr4");
    rd(3, 0, "t6_ctr3");

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      InstrValidM = ($urandom_range(3) != 0);
      case ($urandom_range(4))
        0: InstrClassM = 4'b0001;
        1: InstrClassM = 4'b0010;
        2: InstrClassM = 4'b0110;
        3: InstrClassM = 4'b1010;
        default: InstrClassM = 4'b0000;
      endcase
      BPWrongM        = ($urandom_range(2) == 0);
      BPDirPredWrongM = ($urandom_range(2) == 0);
      BTAWrongM       = ($urandom_range(2) == 0);
      RASPredPCWrongM = ($urandom_range(2) == 0);
      IClassWrongM    = ($urandom_range(2) == 0);
      StallW   = ($urandom_range(3) == 0);
      FlushW   = ($urandom_range(7) == 0);
      RdReq    = 1'($urandom_range(1));
      CtrSel   = 4'($urandom_range(15));
      WrEn     = ($urandom_range(15) == 0);
      if ($urandom_range(1) == 1)
        WrData = CW'(MAXV - longint'($urandom_range(3)));
      else
        WrData = CW'($urandom);
      MaskWrEn = ($urandom_range(31) == 0);
      MaskData = ($urandom_range(3) == 0) ? NC'($urandom) : '0;
      ClearAll = ($urandom_range(511) == 0);
      reset    = (c >= 2000 && c < 2002);
      tick();
    end
    reset = 0;
    RdReq = 1; CtrSel = 0; tick();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
